// File: rtl/shift_seq.sv
// Multi-cycle sequencer for the one-position shift unit.
// It performs an N-position rotate, or a single pass, by looping the shifter output back into tmp.
module shift_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       count,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] sh_a,
  input  logic [WIDTH-1:0] sh_w,
  input  logic             sh_cf,
  output logic             fbus,
  output logic             flbus,
  output logic             frbus,
  output logic [WIDTH-1:0] result,
  output logic             cf,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PASS, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] tmp;
  logic [1:0]       op_reg;
  logic [2:0]       cnt;

  assign sh_a = tmp;

  // The shifter controls are registered alongside the state so they never glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tmp    <= '0;
      op_reg <= 2'b00;
      cnt    <= 3'd0;
      result <= '0;
      cf     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      fbus   <= 1'b0;
      flbus  <= 1'b0;
      frbus  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tmp    <= bus_in;
            op_reg <= op;
            cnt    <= count;
            busy   <= 1'b1;
            // A zero-distance rotate is treated as a pass so cnt never wraps.
            if (op == 2'b00 || op == 2'b11 || count == 3'd0) begin
              state <= PASS;
              fbus  <= 1'b1;
            end else begin
              state <= SHIFT;
              flbus <= (op == 2'b01);
              frbus <= (op == 2'b10);
            end
          end
        end
        PASS: begin
          tmp    <= sh_w;
          cf     <= sh_cf;
          result <= sh_w;
          fbus   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        SHIFT: begin
          tmp <= sh_w;
          cf  <= sh_cf;
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            result <= sh_w;
            flbus  <= 1'b0;
            frbus  <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            flbus <= (op_reg == 2'b01);
            frbus <= (op_reg == 2'b10);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle sequencer that drives the model machine's combinational shift unit: it latches an operand from the data bus, steers the shifter's control lines (`fbus`/`flbus`/`frbus`) for N cycles and loops the shifter output back into a temporary register. It also captures the shifter's carry into a flag register and reports completion with a handshake. It sits between the microcontroller and the shift unit, turning a one-position rotator into an N-position rotate/pass instruction.

## Interface
Parameters:
- `WIDTH`, 8, data width. Fixed at 8 for the model machine.

Ports:
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse. Sampled only in IDLE.
- `op`  in  2  operation: 00 = pass, 01 = rotate left, 10 = rotate right, 11 = pass (reserved).
- `count`  in  3  rotate distance, 0–7. Ignored for pass.
- `bus_in`  in  8  operand from the data bus. Latched with `start`.
- `sh_a`  out  8  operand to the shift unit `a` input. Always equals `tmp`.
- `sh_w`  in  8  shift unit result.
- `sh_cf`  in  1  shift unit carry.
- `fbus`, `flbus`, `frbus`  out  1 each  shift unit controls. At most one is high in any cycle.
- `result`  out  8  final value. Holds until the next accepted `start`.
- `cf`  out  1  carry flag. Equals the carry of the last shifter step.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- State machine states: IDLE, PASS, SHIFT, DONE.
- IDLE:
  - `busy`=0 and all shifter controls are 0, so the shifter output is high-Z and the bus is released.
  - On `start`=1: `tmp`<=`bus_in`, latch `op`, `cnt`<=`count`.
  - Next state is PASS if `op`∈{00,11} or `count`=0; otherwise SHIFT.
- PASS:
  - `fbus`=1 for exactly one cycle.
  - `tmp`<=`sh_w`, `cf`<=`sh_cf` (the shifter gives 0).
  - Next state is DONE.
- SHIFT:
  - `flbus`=1 if `op`=01, `frbus`=1 if `op`=10.
  - Each cycle: `tmp`<=`sh_w`, `cf`<=`sh_cf`, `cnt`<=`cnt`-1.
  - When `cnt`=1 at the edge, next state is DONE.
- DONE:
  - `done`=1, controls all 0, `result`=`tmp`.
  - Next state is IDLE unconditionally.
- Carry semantics:
  - Rotate left: `cf` = final bit0, i.e. the old bit7 of the last step.
  - Rotate right: `cf` = final bit7.
  - Pass: `cf`=0.
- `result` is a registered copy of `tmp`, loaded on entry to DONE. `cf` updates only while in PASS or SHIFT.
- `start` while `busy`=1 is ignored. It is not queued.
- `cnt` is a 3-bit counter. It never wraps, because a rotate with `count`=0 takes the PASS path.

## Timing
- Reset values (asynchronous, `rst`=0):
  - State IDLE.
  - `tmp`, `result`, `cnt` = 0.
  - `cf`, `busy`, `done`, `fbus`, `flbus`, `frbus` = 0.
  - `sh_a` = 0.
- Reset mid-operation aborts immediately. Controls drop in the same instant with no further `done`, and `result` clears to 0.
- Latency from the edge that samples `start`:
  - Pass: PASS at cycle 1, `done` at cycle 2.
  - Rotate N (1–7): SHIFT for cycles 1..N, `done` at cycle N+1.
- `busy` is high for cycles 1 through the DONE cycle inclusive. It is low the cycle after DONE, when a new `start` may be accepted.
- Back-to-back: `start` held high through DONE is accepted on the first IDLE edge after DONE, so operations issue every N+2 cycles.
- The controls `fbus`/`flbus`/`frbus` are a glitch-free registered state decode. No two of them are ever high together, including across reset and state transitions.
- `sh_a` changes only on clock edges. The shifter path is combinational and must settle within one cycle.

## Test plan
- Rotate left, `op`=01, `count`=1, `bus_in`=0x81 -> `flbus` high 1 cycle, `result`=0x03, `cf`=1, `done` at cycle 2.
- Rotate right, `op`=10, `count`=3, `bus_in`=0x01 -> `frbus` high 3 cycles, `tmp` sequence 0x80, 0x40, 0x20, `result`=0x20, `cf`=0, `done` at cycle 4.
- Rotate left, `count`=7, `bus_in`=0xB4 -> `result`=0x5A, `cf`=0, `done` at cycle 8.
- Pass, `op`=00, `bus_in`=0x3C (also `op`=01 with `count`=0) -> `fbus` high exactly 1 cycle, `result`=0x3C, `cf`=0, `done` at cycle 2.
- `start` pulsed during SHIFT with a different `bus_in` -> ignored, and the original result completes unchanged.
- `rst` asserted at cycle 2 of a `count`=5 rotate -> all outputs 0 immediately, no `done`, and the next `start` after release behaves normally.
